// File: rtl/sync_fifo_param.sv
// sync_fifo_param: synchronous FIFO with occupancy flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is a standard registered read.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int AF_LEVEL = 2**ADDR_W - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr_q, rd_ptr_q, count_q, count_d;
    logic [DATA_W-1:0] dout_q;
    logic              valid_q, full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
    logic              rd_acc, wr_acc, load, valid_d, empty_d;

`ifdef SYNC_FIFO_FWFT_EN
    // The output register is a storage slot: a pop frees it and RAM refills it on the same edge.
    assign rd_acc  = rd_en & valid_q;
    assign load    = (wr_ptr_q != rd_ptr_q) & (~valid_q | rd_acc);
    assign valid_d = load | (valid_q & ~rd_acc);
    assign empty_d = ~valid_d;
`else
    assign rd_acc  = rd_en & ~empty_q;
    assign load    = rd_acc;
    assign valid_d = rd_acc;
    assign empty_d = count_d == '0;
`endif
    assign wr_acc  = wr_en & (~full_q | rd_acc);
    assign count_d = count_q + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);

    always_ff @(posedge clk) begin
        if (wr_acc && !rst)
            mem[wr_ptr_q[ADDR_W-1:0]] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(wr_acc);
            rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(load);
            count_q  <= count_d;
            if (load)
                dout_q <= mem[rd_ptr_q[ADDR_W-1:0]];
            valid_q  <= valid_d;
            full_q   <= count_d == (ADDR_W+1)'(DEPTH);
            empty_q  <= empty_d;
            af_q     <= count_d >= (ADDR_W+1)'(AF_LEVEL);
            ae_q     <= count_d <= (ADDR_W+1)'(AE_LEVEL);
            ovf_q    <= wr_en & ~wr_acc;
            unf_q    <= rd_en & ~rd_acc;
        end
    end

    assign dout         = dout_q;
    assign valid        = valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (default 8x64 build).
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst, wr_en, rd_en;
    logic [7:0] din, dout;
    logic       valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [6:0] count;
    int         n_asrt = 0;
    int         n_fail = 0;

    sync_fifo_param dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .valid(valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        tick();
        wr_en = 1'b1; rd_en = 1'b1; din = 8'hEE;
        tick();
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_ae", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_valid", valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        check("rst_dout", dout, 0);
        rst = 1'b0; rd_en = 1'b0;
`ifdef SYNC_FIFO_FWFT_EN
        wr_en = 1'b1; din = 8'h33;
        tick();
        wr_en = 1'b0;
        check("fwft_n_valid", valid, 0);
        check("fwft_n_count", count, 1);
        tick();
        check("fwft_n1_valid", valid, 1);
        check("fwft_n1_dout", dout, 8'h33);
        check("fwft_n1_empty", empty, 0);
        check("fwft_n1_count", count, 1);
        rd_en = 1'b1;
        tick();
        check("fwft_pop_valid", valid, 0);
        check("fwft_pop_empty", empty, 1);
        check("fwft_pop_count", count, 0);
        tick();
        check("fwft_unf", underflow, 1);
        rd_en = 1'b0; wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = 8'hA0 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        check("fwft_head", dout, 8'hA0);
        check("fwft_cnt3", count, 3);
        rd_en = 1'b1;
        for (int i = 1; i < 3; i++) begin
            tick();
            check("fwft_seq", dout, 8'hA0 + 8'(i));
            check("fwft_seq_valid", valid, 1);
        end
        tick();
        rd_en = 1'b0;
        check("fwft_end_empty", empty, 1);
        check("fwft_end_count", count, 0);
`else
        wr_en = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            din = 8'(i);
            tick();
            if (i == 4)  check("ae_at4", almost_empty, 1);
            if (i == 5)  check("ae_at5", almost_empty, 0);
            if (i == 59) check("af_at59", almost_full, 0);
            if (i == 60) check("af_at60", almost_full, 1);
            if (i == 63) check("full_at63", full, 0);
        end
        check("full_at64", full, 1);
        check("count_64", count, 64);
        din = 8'hAA;
        tick();
        check("ovf_pulse", overflow, 1);
        check("ovf_count", count, 64);
        rd_en = 1'b1; din = 8'h41;
        tick();
        check("both_full_dout", dout, 8'h01);
        check("both_full_valid", valid, 1);
        check("both_full_count", count, 64);
        check("both_full_full", full, 1);
        check("ovf_one_cycle", overflow, 0);
        wr_en = 1'b0;
        for (int j = 0; j < 64; j++) begin
            tick();
            check("drain_dout", dout, 8'(j + 2));
            check("drain_valid", valid, 1);
        end
        check("drained_count", count, 0);
        check("drained_empty", empty, 1);
        tick();
        check("unf_pulse", underflow, 1);
        check("unf_valid", valid, 0);
        check("unf_dout_hold", dout, 8'h41);
        check("unf_count", count, 0);
        rd_en = 1'b0;
        tick();
        check("unf_one_cycle", underflow, 0);
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h66;
        tick();
        check("both_empty_unf", underflow, 1);
        check("both_empty_count", count, 1);
        check("both_empty_valid", valid, 0);
        wr_en = 1'b0;
        tick();
        check("both_empty_rd", dout, 8'h66);
        check("both_empty_count0", count, 0);
        rd_en = 1'b0; wr_en = 1'b1;
        din = 8'h10; tick();
        din = 8'h11; tick();
        rd_en = 1'b1; din = 8'h12;
        tick();
        check("mid_both_dout", dout, 8'h10);
        check("mid_both_count", count, 2);
        wr_en = 1'b0;
        tick();
        check("mid_rd1", dout, 8'h11);
        tick();
        check("mid_rd2", dout, 8'h12);
        check("mid_empty", empty, 1);
        rd_en = 1'b0; wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = 8'h80 + 8'(i);
            tick();
        end
        check("pre_rst_count", count, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_valid", valid, 0);
        din = 8'h5C;
        tick();
        wr_en = 1'b0;
        check("post_rst_count", count, 1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("post_rst_dout", dout, 8'h5C);
        check("post_rst_valid", valid, 1);
        check("post_rst_empty", empty, 1);
`endif
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
